apb3_master: RTL

APB3_MASTER -- requirements
Module: apb3_master

---
 rtl/apb3_master.sv | 121 ++++++++++++
 1 files changed

// File: rtl/apb3_master.sv
// Purpose: turns a valid/ready command into one APB3 transfer and reports a one-cycle response.
// Latency: handshake at N, SETUP at N+1, ACCESS at N+2, rsp_valid at N+3 at best (one transfer per 3 cycles).
// Backpressure: cmd_ready is high only in IDLE; rsp_valid cannot be stalled; PREADY stretches ACCESS up to TIMEOUT cycles.
module apb3_master #(
  parameter int APB3_AW = 32,
  parameter int APB3_DW = 32,
  parameter int TIMEOUT = 256
) (
  input  logic               PCLK,
  input  logic               PRESETN,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [APB3_AW-1:0] cmd_addr,
  input  logic [APB3_DW-1:0] cmd_wdata,
  output logic               rsp_valid,
  output logic [APB3_DW-1:0] rsp_rdata,
  output logic               rsp_err,
  output logic               rsp_timeout,
  output logic [APB3_AW-1:0] PADDR,
  output logic [APB3_DW-1:0] PWDATA,
  output logic               PWRITE,
  output logic               PSEL,
  output logic               PENABLE,
  input  logic [APB3_DW-1:0] PRDATA,
  input  logic               PREADY,
  input  logic               PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  // Last counter value before giving up; meaningless (and unused) when TIMEOUT is 0.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] wait_cnt;
  logic        hs;
  logic        done;
  logic        timeout_hit;

  assign hs          = cmd_valid & cmd_ready;
  assign done        = (state == ACCESS) & PREADY;
  // A slave that answers on the very last allowed cycle still completes normally.
  assign timeout_hit = (TIMEOUT != 0) && (state == ACCESS) && !PREADY && (wait_cnt == TO_LAST);

  // State register.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: SETUP always lasts one cycle, ACCESS ends on PREADY or timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (done || timeout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus control and command acceptance decoded from the current state.
  always_comb begin
    cmd_ready = 1'b0;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    case (state)
      IDLE:    cmd_ready = 1'b1;
      SETUP:   PSEL      = 1'b1;
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
      end
      default: cmd_ready = 1'b0;
    endcase
  end

  // Address/data phase registers: loaded only on a handshake, so they hold through the transfer and in IDLE.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      PADDR  <= '0;
      PWDATA <= '0;
      PWRITE <= 1'b0;
    end else if (hs) begin
      PADDR  <= cmd_addr;
      PWDATA <= cmd_wdata;
      PWRITE <= cmd_write;
    end
  end

  // Wait counter: cleared while in SETUP so it starts at 0 in the first ACCESS cycle.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN)                      wait_cnt <= '0;
    else if (state == SETUP)           wait_cnt <= '0;
    else if (state == ACCESS && !PREADY) wait_cnt <= wait_cnt + 16'd1;
  end

  // Response registers: rsp_valid pulses for one cycle, the payload holds until the next completion.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= done | timeout_hit;
      if (done) begin
        rsp_rdata   <= PWRITE ? '0 : PRDATA;
        rsp_err     <= PSLVERR;
        rsp_timeout <= 1'b0;
      end else if (timeout_hit) begin
        rsp_rdata   <= '0;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule
